train_seq: RTL and testbench



---
 rtl/train_seq.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_train_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/train_seq.sv
// train_seq -- training sequencer in front of the array network.
//
// Holds a batch of BATCH samples and replays them for a programmed number of
// epochs, driving the sample buses and control strobes of the array. It also
// captures the batch cost that the array reports after every weight update.
//
// Ports
//   clk            clock, everything on the rising edge
//   rst            asynchronous, active-low reset
//   i_ld_en        sample write strobe (honoured only in IDLE)
//   i_ld_addr      sample slot; slots at or above BATCH are ignored
//   i_ld_k/i_ld_t  sample inputs / targets to store
//   i_start        start pulse (IDLE only); latches i_n_epoch and i_lr
//   i_abort        abort request (see FSM notes below)
//   i_n_epoch      epochs to run
//   i_lr           learning rate
//   i_cost         batch cost from the array, sampled at the end of WRITE
//   o_k/o_t        current sample, registered when a sample is selected
//   o_lr           latched learning rate
//   o_rst_btch     batch accumulator clear to the array
//   o_accu         accumulate strobe to the array
//   o_wr           weight-update strobe to the array
//   o_busy         high outside IDLE and DONE
//   o_done         one-cycle completion pulse
//   o_epoch        completed epochs
//   o_cost         cost captured at the most recent o_wr
//   o_cost_min     lowest signed cost seen this run   (COST_TRACK_EN only)
//   o_best_epoch   epoch number that produced it     (COST_TRACK_EN only)
//   o_state        current FSM state, for debug and checkers
//
// Optional feature macro: COST_TRACK_EN adds o_cost_min / o_best_epoch.
//
// Strobe protocol: there is no back-pressure. o_rst_btch, o_accu, o_wr and
// o_done are single-cycle pulses decoded from the FSM state, so at most one
// of the array strobes is high in any cycle. o_k/o_t are stable from the
// first SETTLE cycle of a sample through its ACCU cycle, and the array must
// present i_cost during the WRITE cycle.

module train_seq #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32,
  parameter int BATCH  = 4,
  parameter int SETTLE = 3,
  parameter int EPW    = 16,
  localparam int AW    = (BATCH <= 1) ? 1 : $clog2(BATCH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ld_en,
  input  logic [AW-1:0]           i_ld_addr,
  input  logic [N_IN*WIDTH-1:0]   i_ld_k,
  input  logic [N_OUT*WIDTH-1:0]  i_ld_t,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [EPW-1:0]          i_n_epoch,
  input  logic [WIDTH-1:0]        i_lr,
  input  logic [WIDTH-1:0]        i_cost,
  output logic [N_IN*WIDTH-1:0]   o_k,
  output logic [N_OUT*WIDTH-1:0]  o_t,
  output logic [WIDTH-1:0]        o_lr,
  output logic                    o_rst_btch,
  output logic                    o_accu,
  output logic                    o_wr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [EPW-1:0]          o_epoch,
  output logic [WIDTH-1:0]        o_cost,
`ifdef COST_TRACK_EN
  output logic [WIDTH-1:0]        o_cost_min,
  output logic [EPW-1:0]          o_best_epoch,
`endif
  output logic [2:0]              o_state
);

  localparam int KW = N_IN * WIDTH;
  localparam int TW = N_OUT * WIDTH;
  localparam int MW = KW + TW;
  // Memory is sized to the full address space so every address is a legal
  // index; writes to slots at or above BATCH are filtered out below.
  localparam int MD = 1 << AW;
  localparam int SW = (SETTLE <= 1) ? 1 : $clog2(SETTLE);

  localparam logic [AW:0]   BATCH_W     = (AW+1)'(BATCH);
  localparam logic [AW-1:0] IDX_LAST    = AW'(BATCH - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_SETTLE = 3'd2,
    S_ACCU   = 3'd3,
    S_WRITE  = 3'd4,
    S_RSTB   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          state;
  state_t          state_d;

  logic [MW-1:0]   mem [0:MD-1];
  logic [AW-1:0]   idx;
  logic [SW-1:0]   cnt;
  logic [EPW-1:0]  n_epoch_q;
  logic [EPW-1:0]  epoch_inc;
  // abort_q: the current batch was abandoned part-way (no o_wr, no epoch
  // count). defer_q: abort arrived during WRITE, so the batch completed and
  // only the return path changes.
  logic            abort_q;
  logic            defer_q;

  logic            start_go;
  logic            abort_now;
  logic            load_en;
  logic [AW-1:0]   load_idx;
  logic            ld_ok;

  assign epoch_inc = o_epoch + EPW'(1);
  assign o_state   = state;
  assign ld_ok     = (state == S_IDLE) && i_ld_en && ({1'b0, i_ld_addr} < BATCH_W);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state, strobes and datapath controls
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state;
    start_go   = 1'b0;
    abort_now  = 1'b0;
    load_en    = 1'b0;
    load_idx   = '0;
    o_rst_btch = 1'b0;
    o_accu     = 1'b0;
    o_wr       = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          start_go = 1'b1;
          // A zero-epoch run completes at once without touching the array.
          state_d  = (i_n_epoch == '0) ? S_DONE : S_CLR;
        end
      end

      S_CLR: begin
        o_rst_btch = 1'b1;
        o_busy     = 1'b1;
        if (i_abort) begin
          abort_now = 1'b1;
          state_d   = S_RSTB;
        end else begin
          load_en  = 1'b1;
          load_idx = '0;
          state_d  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        o_busy = 1'b1;
        if (i_abort) begin
          abort_now = 1'b1;
          state_d   = S_RSTB;
        end else if (cnt == SETTLE_LAST) begin
          state_d = S_ACCU;
        end
      end

      S_ACCU: begin
        o_accu = 1'b1;
        o_busy = 1'b1;
        // Abort wins over the normal advance.
        if (i_abort) begin
          abort_now = 1'b1;
          state_d   = S_RSTB;
        end else if (idx == IDX_LAST) begin
          state_d = S_WRITE;
        end else begin
          load_en  = 1'b1;
          load_idx = idx + AW'(1);
          state_d  = S_SETTLE;
        end
      end

      S_WRITE: begin
        o_wr    = 1'b1;
        o_busy  = 1'b1;
        state_d = S_RSTB;
      end

      S_RSTB: begin
        o_rst_btch = 1'b1;
        o_busy     = 1'b1;
        if (abort_q || defer_q) begin
          state_d = S_IDLE;
        end else if (epoch_inc == n_epoch_q) begin
          state_d = S_DONE;
        end else begin
          load_en  = 1'b1;
          load_idx = '0;
          state_d  = S_SETTLE;
        end
      end

      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sample memory: not reset, so contents survive a reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem[i_ld_addr] <= {i_ld_k, i_ld_t};
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      cnt       <= '0;
      n_epoch_q <= '0;
      abort_q   <= 1'b0;
      defer_q   <= 1'b0;
      o_k       <= '0;
      o_t       <= '0;
      o_lr      <= '0;
      o_epoch   <= '0;
      o_cost    <= '0;
    end else begin
      if (start_go) begin
        n_epoch_q <= i_n_epoch;
        o_lr      <= i_lr;
        idx       <= '0;
        o_epoch   <= '0;
        o_cost    <= '0;
        abort_q   <= 1'b0;
        defer_q   <= 1'b0;
      end

      // A new sample is presented on every entry to SETTLE and then held.
      if (load_en) begin
        {o_k, o_t} <= mem[load_idx];
        idx        <= load_idx;
        cnt        <= '0;
      end else if (state == S_SETTLE) begin
        cnt <= cnt + SW'(1);
      end

      if (abort_now) begin
        abort_q <= 1'b1;
      end

      if (state == S_WRITE) begin
        o_cost <= i_cost;
        if (i_abort) begin
          defer_q <= 1'b1;
        end
      end

      if (state == S_RSTB) begin
        // A discarded partial batch does not count as a completed epoch.
        if (!abort_q) begin
          o_epoch <= epoch_inc;
        end
        abort_q <= 1'b0;
        defer_q <= 1'b0;
      end
    end
  end

`ifdef COST_TRACK_EN
  // ---------------------------------------------------------------------
  // Best-cost tracking: signed minimum of the costs seen this run.
  // ---------------------------------------------------------------------
  localparam logic [WIDTH-1:0] COST_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_cost_min   <= '0;
      o_best_epoch <= '0;
    end else if (start_go) begin
      o_cost_min   <= COST_MAX;
      o_best_epoch <= '0;
    end else if ((state == S_WRITE) && ($signed(i_cost) < $signed(o_cost_min))) begin
      o_cost_min   <= i_cost;
      o_best_epoch <= epoch_inc;
    end
  end
`else
  // Cost tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_train_seq.sv
// Directed bench for train_seq. Main instance uses the default parameters;
// a second instance covers BATCH=1, SETTLE=1.

module tb_train_seq;

  localparam logic [31:0] LR = 32'h0010_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  // stimulus shared by both instances
  logic         i_ld_en = 1'b0;
  logic [1:0]   i_ld_addr = '0;
  logic [63:0]  i_ld_k = '0;
  logic [63:0]  i_ld_t = '0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [15:0]  i_n_epoch = '0;
  logic [31:0]  i_lr = '0;
  logic [31:0]  i_cost = '0;

  // main instance outputs
  logic [63:0]  o_k, o_t;
  logic [31:0]  o_lr, o_cost;
  logic         o_rst_btch, o_accu, o_wr, o_busy, o_done;
  logic [15:0]  o_epoch;
  logic [2:0]   o_state;
`ifdef COST_TRACK_EN
  logic [31:0]  o_cost_min;
  logic [15:0]  o_best_epoch;
`endif

  // boundary instance
  logic         b_ld_en = 1'b0;
  logic [0:0]   b_ld_addr = '0;
  logic         b_start = 1'b0;
  logic [63:0]  b_k, b_t;
  logic [31:0]  b_lr, b_cost;
  logic         b_rb, b_accu, b_wr, b_busy, b_done;
  logic [15:0]  b_epoch;
  logic [2:0]   b_state;
`ifdef COST_TRACK_EN
  logic [31:0]  b_cost_min;
  logic [15:0]  b_best;
`endif

  train_seq dut (
    .clk(clk), .rst(rst),
    .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr), .i_ld_k(i_ld_k), .i_ld_t(i_ld_t),
    .i_start(i_start), .i_abort(i_abort), .i_n_epoch(i_n_epoch),
    .i_lr(i_lr), .i_cost(i_cost),
    .o_k(o_k), .o_t(o_t), .o_lr(o_lr),
    .o_rst_btch(o_rst_btch), .o_accu(o_accu), .o_wr(o_wr),
    .o_busy(o_busy), .o_done(o_done), .o_epoch(o_epoch), .o_cost(o_cost),
`ifdef COST_TRACK_EN
    .o_cost_min(o_cost_min), .o_best_epoch(o_best_epoch),
`endif
    .o_state(o_state)
  );

  train_seq #(.BATCH(1), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst),
    .i_ld_en(b_ld_en), .i_ld_addr(b_ld_addr), .i_ld_k(i_ld_k), .i_ld_t(i_ld_t),
    .i_start(b_start), .i_abort(i_abort), .i_n_epoch(i_n_epoch),
    .i_lr(i_lr), .i_cost(i_cost),
    .o_k(b_k), .o_t(b_t), .o_lr(b_lr),
    .o_rst_btch(b_rb), .o_accu(b_accu), .o_wr(b_wr),
    .o_busy(b_busy), .o_done(b_done), .o_epoch(b_epoch), .o_cost(b_cost),
`ifdef COST_TRACK_EN
    .o_cost_min(b_cost_min), .o_best_epoch(b_best),
`endif
    .o_state(b_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] exp_q[$];

  logic [63:0] sk [0:3];
  logic [63:0] st [0:3];
  logic [31:0] cost_tab [0:3];

  typedef struct {
    logic [15:0] n;
    int          abort_at;
    int          restart_at;
    logic [31:0] m_accu;
    logic [31:0] m_wr;
    logic [31:0] m_rb;
    logic [31:0] m_done;
    logic [31:0] m_busy;
    int          done_cyc;
    int          end_cyc;
    int          n_accu;
    int          n_wr;
    int          n_rb;
    logic        chk_ep;
    logic [15:0] epoch;
    logic [31:0] cost;
    logic [31:0] cmin;
    logic [15:0] best;
  } scen_t;

  scen_t tab [0:5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [63:0] k, input logic [63:0] t);
    i_ld_en = 1'b1; i_ld_addr = a; i_ld_k = k; i_ld_t = t;
    tick();
    i_ld_en = 1'b0;
  endtask

  task automatic fill_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({sk[i % 4], st[i % 4]});
  endtask

  // Runs one scenario: start is high in cycle 0, cycle c is observed #1
  // after the c-th following edge.
  task automatic run_scen(input int id, input scen_t s);
    logic [31:0]  m_accu, m_wr, m_rb, m_done, m_busy;
    int           done_cyc, end_cyc, n_accu, n_wr, n_rb, n_excl;
    logic [127:0] e;
    string        p;
    p = $sformatf("s%0d", id);
    m_accu = '0; m_wr = '0; m_rb = '0; m_done = '0; m_busy = '0;
    done_cyc = 0; end_cyc = 0; n_accu = 0; n_wr = 0; n_rb = 0; n_excl = 0;
    fill_exp(s.n_accu);
    i_n_epoch = s.n;
    i_lr      = LR;
    i_cost    = 32'h0;
    i_start   = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      i_start = 1'b0; i_abort = 1'b0; i_ld_en = 1'b0;
      // must have been latched at start
      if (c == 1) begin i_n_epoch = 16'd5; i_lr = 32'hDEAD_BEEF; end
      if (o_accu) begin
        n_accu++;
        if (c < 32) m_accu[c] = 1'b1;
        if (exp_q.size() == 0) begin
          chk({p, "_accu_extra"}, 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk({p, "_sample"}, {o_k, o_t}, e);
        end
      end
      if (o_rst_btch) begin n_rb++; if (c < 32) m_rb[c] = 1'b1; end
      if (o_done) begin
        if (done_cyc == 0) done_cyc = c;
        if (c < 32) m_done[c] = 1'b1;
      end
      if (o_busy && c < 32) m_busy[c] = 1'b1;
      if (int'(o_rst_btch) + int'(o_accu) + int'(o_wr) > 1) n_excl++;
      if (c > 1 && !o_busy && !o_done) begin end_cyc = c; break; end
      if (o_wr) begin
        if (c < 32) m_wr[c] = 1'b1;
        i_cost = cost_tab[n_wr % 4];
        n_wr++;
      end
      if (c == s.abort_at) i_abort = 1'b1;
      if (c == s.restart_at) begin
        i_start = 1'b1; i_ld_en = 1'b1; i_ld_addr = 2'd0;
        i_ld_k = '1; i_ld_t = '1;
      end
    end
    chk({p, "_accu_mask"}, m_accu, s.m_accu);
    chk({p, "_wr_mask"},   m_wr,   s.m_wr);
    chk({p, "_rb_mask"},   m_rb,   s.m_rb);
    chk({p, "_done_mask"}, m_done, s.m_done);
    chk({p, "_busy_mask"}, m_busy, s.m_busy);
    chk({p, "_done_cyc"},  done_cyc, s.done_cyc);
    chk({p, "_end_cyc"},   end_cyc,  s.end_cyc);
    chk({p, "_n_accu"},    n_accu,   s.n_accu);
    chk({p, "_n_wr"},      n_wr,     s.n_wr);
    chk({p, "_n_rb"},      n_rb,     s.n_rb);
    chk({p, "_exclusive"}, n_excl,   0);
    chk({p, "_exp_left"},  exp_q.size(), 0);
    chk({p, "_lr"},        o_lr,     LR);
    chk({p, "_cost"},      o_cost,   s.cost);
    if (s.chk_ep) chk({p, "_epoch"}, o_epoch, s.epoch);
`ifdef COST_TRACK_EN
    chk({p, "_cost_min"},   o_cost_min,   s.cmin);
    chk({p, "_best_epoch"}, o_best_epoch, s.best);
`endif
    exp_q.delete();
    repeat (2) tick();
  endtask

  initial begin
    logic [15:0] m_a, m_w, m_r, m_d;
    int          b_end;
    logic [127:0] e;

    sk[0] = 64'h0800_0000_0500_0000; st[0] = 64'h0100_0000_0000_0000;
    sk[1] = 64'h0200_0000_0300_0000; st[1] = 64'h0000_0000_0100_0000;
    sk[2] = 64'h0100_0000_0700_0000; st[2] = 64'h0100_0000_0100_0000;
    sk[3] = 64'h0400_0000_0600_0000; st[3] = 64'h0000_0000_0000_0000;
    cost_tab[0] = 32'h0030_0000; cost_tab[1] = 32'h0020_0000;
    cost_tab[2] = 32'h0028_0000; cost_tab[3] = 32'h0040_0000;

    //          n  abort restart  accu          wr            rb            done          busy         done end acc wr rb chk epoch cost          cmin          best
    tab[0] = '{16'd1,  0,  0, 32'h0002_2220, 32'h0004_0000, 32'h0008_0002, 32'h0010_0000, 32'h000F_FFFE, 20, 21,  4, 1, 2, 1'b1, 16'd1, 32'h0030_0000, 32'h0030_0000, 16'd1};
    tab[1] = '{16'd0,  0,  0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 32'h0000_0000,  1,  2,  0, 0, 0, 1'b1, 16'd0, 32'h0000_0000, 32'h7FFF_FFFF, 16'd0};
    tab[2] = '{16'd1,  0,  7, 32'h0002_2220, 32'h0004_0000, 32'h0008_0002, 32'h0010_0000, 32'h000F_FFFE, 20, 21,  4, 1, 2, 1'b1, 16'd1, 32'h0030_0000, 32'h0030_0000, 16'd1};
    tab[3] = '{16'd3,  0,  0, 32'h8882_2220, 32'h0004_0000, 32'h0008_0002, 32'h0000_0000, 32'hFFFF_FFFE, 56, 57, 12, 3, 4, 1'b1, 16'd3, 32'h0028_0000, 32'h0020_0000, 16'd2};
    tab[4] = '{16'd3, 29,  0, 32'h0882_2220, 32'h0004_0000, 32'h4008_0002, 32'h0000_0000, 32'h7FFF_FFFE,  0, 31,  6, 1, 3, 1'b1, 16'd1, 32'h0030_0000, 32'h0030_0000, 16'd1};
    tab[5] = '{16'd2, 18,  0, 32'h0002_2220, 32'h0004_0000, 32'h0008_0002, 32'h0000_0000, 32'h000F_FFFE,  0, 20,  4, 1, 2, 1'b0, 16'd0, 32'h0030_0000, 32'h0030_0000, 16'd1};

    // ---------------- reset state ----------------
    #12;
    chk("rst_ctrl", {o_rst_btch, o_accu, o_wr, o_busy, o_done, o_state}, 128'd0);
    chk("rst_kt",   {o_k, o_t}, 128'd0);
    chk("rst_regs", {o_lr, o_epoch, o_cost}, 128'd0);
    rst = 1'b1;
    tick();

    for (int s = 0; s < 4; s++) load(s[1:0], sk[s], st[s]);

    // ---------------- table-driven scenarios ----------------
    for (int i = 0; i < 6; i++) run_scen(i, tab[i]);

    // ---------------- reset mid-epoch ----------------
    i_n_epoch = 16'd1; i_lr = LR; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", o_busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {o_rst_btch, o_accu, o_wr, o_busy, o_done, o_state}, 128'd0);
    chk("mid_rst_kt",   {o_k, o_t}, 128'd0);
    chk("mid_rst_regs", {o_lr, o_epoch, o_cost}, 128'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_state", o_state, 3'd0);
    // memory retained across reset: rerun the single epoch
    run_scen(6, tab[0]);

    // ---------------- BATCH=1, SETTLE=1 ----------------
    b_ld_en = 1'b1; b_ld_addr = 1'b0; i_ld_k = sk[2]; i_ld_t = st[2];
    tick();
    b_ld_en = 1'b0;
    m_a = '0; m_w = '0; m_r = '0; m_d = '0; b_end = 0;
    i_n_epoch = 16'd2; i_lr = LR; b_start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      b_start = 1'b0;
      if (b_accu) begin
        m_a[c] = 1'b1;
        e = {sk[2], st[2]};
        chk("b_sample", {b_k, b_t}, e);
      end
      if (b_wr)   m_w[c] = 1'b1;
      if (b_rb)   m_r[c] = 1'b1;
      if (b_done) m_d[c] = 1'b1;
      if (c > 1 && !b_busy && !b_done) begin b_end = c; break; end
    end
    chk("b_accu_mask", m_a, 16'h0088);
    chk("b_wr_mask",   m_w, 16'h0110);
    chk("b_rb_mask",   m_r, 16'h0222);
    chk("b_done_mask", m_d, 16'h0400);
    chk("b_end_cyc",   b_end, 11);
    chk("b_epoch",     b_epoch, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
